// File: rtl/pipe_hazard_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Pipeline-side view of the hazard controller (hazard sources in,
//            stall/flush/forward strobes and status out).
// Revision : 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1_i;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_i;
  logic                      id_use_rs1_i;
  logic                      id_use_rs2_i;
  logic [REG_ADDR_WIDTH-1:0] ex_rs1_i;
  logic [REG_ADDR_WIDTH-1:0] ex_rs2_i;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_i;
  logic                      ex_memread_i;
  logic                      ex_regwrite_i;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_i;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_i;
  logic                      mem_regwrite_i;
  logic                      wb_regwrite_i;
  logic                      ex_redirect_i;
  logic                      dmem_req_i;
  logic                      dmem_ready_i;
  logic                      pc_stall_o;
  logic                      if_id_stall_o;
  logic                      id_ex_stall_o;
  logic                      ex_mem_stall_o;
  logic                      mem_wb_stall_o;
  logic                      if_id_flush_o;
  logic                      id_ex_flush_o;
  logic [1:0]                fwd_a_sel_o;
  logic [1:0]                fwd_b_sel_o;
  logic                      mem_timeout_o;
  logic [CNT_WIDTH-1:0]      stall_cnt_o;
  logic [CNT_WIDTH-1:0]      flush_cnt_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           ex_rs1_i, ex_rs2_i, ex_rd_i, ex_memread_i, ex_regwrite_i,
           mem_rd_i, wb_rd_i, mem_regwrite_i, wb_regwrite_i,
           ex_redirect_i, dmem_req_i, dmem_ready_i,
    input  pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
           mem_wb_stall_o, if_id_flush_o, id_ex_flush_o,
           fwd_a_sel_o, fwd_b_sel_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           ex_rs1_i, ex_rs2_i, ex_rd_i, ex_memread_i, ex_regwrite_i,
           mem_rd_i, wb_rd_i, mem_regwrite_i, wb_regwrite_i,
           ex_redirect_i, dmem_req_i, dmem_ready_i,
    output pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
           mem_wb_stall_o, if_id_flush_o, id_ex_flush_o,
           fwd_a_sel_o, fwd_b_sel_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Five-stage pipeline hazard controller: stall/flush strobes, EX
//            operand forwarding, memory-wait freeze, timeout and counters.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit FWD_EN         = 1'b1,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);

  localparam int                     c_wait_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_wait_w-1:0]    c_wait_last = c_wait_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_wait_w-1:0]    c_wait_max  = c_wait_w'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_wait_w-1:0]   r_wait_cnt;
  logic                  r_timeout;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic [CNT_WIDTH-1:0]  r_flush_cnt;

  logic       w_freeze, w_ex_wr, w_mem_wr, w_wb_wr, w_rs1_used, w_rs2_used;
  logic       w_load_use, w_raw, w_redirect_taken;
  logic       w_pc_stall, w_if_id_stall, w_back_stall, w_if_id_flush, w_id_ex_flush;
  logic [1:0] w_fwd_a, w_fwd_b;

  // x0 is never a real producer or consumer, so zero indices are masked here.
  assign w_freeze   = bus.dmem_req_i & ~bus.dmem_ready_i;
  assign w_ex_wr    = bus.ex_regwrite_i  & (bus.ex_rd_i  != '0);
  assign w_mem_wr   = bus.mem_regwrite_i & (bus.mem_rd_i != '0);
  assign w_wb_wr    = bus.wb_regwrite_i  & (bus.wb_rd_i  != '0);
  assign w_rs1_used = bus.id_use_rs1_i & (bus.id_rs1_i != '0);
  assign w_rs2_used = bus.id_use_rs2_i & (bus.id_rs2_i != '0);

  assign w_load_use = bus.ex_memread_i & w_ex_wr &
                      ((w_rs1_used & (bus.id_rs1_i == bus.ex_rd_i)) |
                       (w_rs2_used & (bus.id_rs2_i == bus.ex_rd_i)));

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] src,
    input logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input logic                      mem_wr,
    input logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input logic                      wb_wr
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (mem_wr && (mem_rd == src))     sel = 2'b10;
      else if (wb_wr && (wb_rd == src))  sel = 2'b01;
    end
    return sel;
  endfunction

  generate
    if (FWD_EN) begin : g_fwd
      assign w_raw   = 1'b0;
      assign w_fwd_a = fwd_sel(bus.ex_rs1_i, bus.mem_rd_i, bus.mem_regwrite_i,
                               bus.wb_rd_i, bus.wb_regwrite_i);
      assign w_fwd_b = fwd_sel(bus.ex_rs2_i, bus.mem_rd_i, bus.mem_regwrite_i,
                               bus.wb_rd_i, bus.wb_regwrite_i);
    end else begin : g_no_fwd
      // Without bypassing, any in-flight writer of a used source blocks ID.
      assign w_raw = (w_rs1_used & ((w_ex_wr  & (bus.id_rs1_i == bus.ex_rd_i))  |
                                    (w_mem_wr & (bus.id_rs1_i == bus.mem_rd_i)) |
                                    (w_wb_wr  & (bus.id_rs1_i == bus.wb_rd_i)))) |
                     (w_rs2_used & ((w_ex_wr  & (bus.id_rs2_i == bus.ex_rd_i))  |
                                    (w_mem_wr & (bus.id_rs2_i == bus.mem_rd_i)) |
                                    (w_wb_wr  & (bus.id_rs2_i == bus.wb_rd_i))));
      assign w_fwd_a = 2'b00;
      assign w_fwd_b = 2'b00;
    end
  endgenerate

  always_comb begin
    w_pc_stall       = 1'b0;
    w_if_id_stall    = 1'b0;
    w_back_stall     = 1'b0;
    w_if_id_flush    = 1'b0;
    w_id_ex_flush    = 1'b0;
    w_redirect_taken = 1'b0;
    if (rst) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_freeze) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_back_stall  = 1'b1;
    end else if (bus.ex_redirect_i) begin
      w_if_id_flush    = 1'b1;
      w_id_ex_flush    = 1'b1;
      w_redirect_taken = 1'b1;
    end else if (w_load_use || w_raw) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
    end
  end

  assign bus.pc_stall_o     = w_pc_stall;
  assign bus.if_id_stall_o  = w_if_id_stall;
  assign bus.id_ex_stall_o  = w_back_stall;
  assign bus.ex_mem_stall_o = w_back_stall;
  assign bus.mem_wb_stall_o = w_back_stall;
  assign bus.if_id_flush_o  = w_if_id_flush;
  assign bus.id_ex_flush_o  = w_id_ex_flush;
  assign bus.fwd_a_sel_o    = rst ? 2'b00 : w_fwd_a;
  assign bus.fwd_b_sel_o    = rst ? 2'b00 : w_fwd_b;
  assign bus.mem_timeout_o  = r_timeout;
  assign bus.stall_cnt_o    = r_stall_cnt;
  assign bus.flush_cnt_o    = r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN:      if (w_freeze) r_state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (bus.dmem_ready_i || !bus.dmem_req_i) r_state <= ST_RUN;
        default:     r_state <= ST_RUN;
      endcase
      // Wait count parks at TIMEOUT_CYCLES; the flag is sticky and the freeze persists.
      if (w_freeze) begin
        if (r_wait_cnt != c_wait_max) r_wait_cnt <= r_wait_cnt + 1'b1;
        if (r_wait_cnt == c_wait_last) r_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_pc_stall && (r_stall_cnt != '1))       r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redirect_taken && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Centralised hazard controller for the five-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It produces per-stage stall/flush strobes and EX-operand forwarding selects, and freezes the whole pipeline on data-memory wait states. It also keeps saturating performance counters and a sticky memory-timeout flag. It sits beside the stage and pipeline-register instances in the core top; it generalises the fixed, hazard-free pipeline with a forwarding-enable mode, a configurable memory-wait timeout and counter width.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- FWD_EN, 1. 1 = full forwarding. 0 = no forwarding; all RAW hazards resolved by stalling.
- TIMEOUT_CYCLES, 64, consecutive memory-wait cycles (≥1) before the timeout flag sets.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1_i, id_rs2_i  in  REG_ADDR_WIDTH  source registers of the instruction in ID.
- id_use_rs1_i, id_use_rs2_i  in  1  the ID instruction actually reads rs1/rs2.
- ex_rs1_i, ex_rs2_i, ex_rd_i  in  REG_ADDR_WIDTH  sources and destination of the instruction in EX.
- ex_memread_i, ex_regwrite_i  in  1  the EX instruction is a load / writes rd.
- mem_rd_i, wb_rd_i  in  REG_ADDR_WIDTH  destination registers in MEM and WB.
- mem_regwrite_i, wb_regwrite_i  in  1  the MEM / WB instruction writes rd.
- ex_redirect_i  in  1  taken branch or jump resolved in EX.
- dmem_req_i, dmem_ready_i  in  1  MEM stage is accessing memory / memory has completed the access.
- pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o, mem_wb_stall_o  out  1  hold the register.
- if_id_flush_o, id_ex_flush_o  out  1  load a bubble into the register.
- fwd_a_sel_o, fwd_b_sel_o  out  2  EX operand source: 00 = register file, 01 = MEM/WB, 10 = EX/MEM.
- mem_timeout_o  out  1  sticky memory-timeout flag.
- stall_cnt_o, flush_cnt_o  out  CNT_WIDTH  saturating counters.

## Operation
Conditions. Writes to register x0 never cause a hazard or a forward.
- Freeze: dmem_req_i & !dmem_ready_i.
- Load-use: ex_memread_i & ex_regwrite_i & ex_rd_i≠0, and ex_rd_i equals a used ID source.
- RAW stall (FWD_EN=0 only): a used ID source is nonzero and equals a writing rd in EX, MEM or WB. The register file does not bypass.

Priority, evaluated combinationally each cycle:
1. Freeze. All five stall outputs = 1, both flushes = 0. A redirect is held and takes effect once the freeze clears, because EX is frozen.
2. Redirect. if_id_flush_o = id_ex_flush_o = 1. The PC is not stalled; it loads the target. A simultaneous load-use condition or RAW stall is ignored.
3. Load-use or RAW stall. pc_stall_o = if_id_stall_o = 1 and id_ex_flush_o = 1 (bubble). EX, MEM and WB advance.
4. Otherwise all stall and flush outputs are 0.

Forwarding, applies only when FWD_EN=1:
- Operand A: if ex_rs1_i≠0, mem_regwrite_i and mem_rd_i==ex_rs1_i, select 10. Else if wb_regwrite_i and wb_rd_i==ex_rs1_i, select 01. Else 00. EX/MEM takes precedence over MEM/WB.
- Operand B: same rule using ex_rs2_i.
- When FWD_EN=0, both selects are constant 00.

Wait-state machine (registered):
- States are RUN and MEM_WAIT.
- RUN → MEM_WAIT on a freeze cycle. MEM_WAIT → RUN when dmem_ready_i is high or dmem_req_i is low.
- wait_cnt has width $clog2(TIMEOUT_CYCLES+1). It increments on each freeze cycle and clears to 0 on any non-freeze cycle.
- mem_timeout_o sets on the edge where a freeze cycle occurs with wait_cnt == TIMEOUT_CYCLES-1. It stays set until rst.
- A timeout does not release the freeze.

Counters:
- stall_cnt_o increments on every cycle with pc_stall_o=1.
- flush_cnt_o increments on every cycle with an honoured redirect (priority 2).
- Both saturate at all-ones.

## Timing
- All stall, flush and forward outputs are combinational on the current inputs and state, with zero-cycle latency.
- While rst=1:
  - all stall outputs = 0;
  - if_id_flush_o = id_ex_flush_o = 1;
  - both forward selects = 00;
  - these values override all other logic.
- On the edge with rst=1: state := RUN, wait_cnt := 0, mem_timeout_o := 0, both counters := 0.
- Reset asserted in the middle of a freeze: at the next edge the state returns to RUN and wait_cnt clears.
- A load-use stall lasts exactly 1 cycle with FWD_EN=1. With FWD_EN=0, the stall lasts until the producer leaves WB, i.e. up to 3 cycles.
- The timeout flag is visible in the cycle after TIMEOUT_CYCLES consecutive freeze cycles.
- Counter and flag updates are visible the cycle after the qualifying cycle.

## Test plan
- Forwarding: ex_rs1=5, mem_rd=5 with mem_regwrite, wb_rd=5 with wb_regwrite → fwd_a_sel=10. Drop mem_regwrite → 01. Set ex_rs1=0 → 00.
- Load-use: ex_memread=1, ex_rd=7, id_rs2=7, id_use_rs2=1 → for exactly one cycle pc_stall=if_id_stall=id_ex_flush=1; stall_cnt 0→1.
- Redirect together with load-use → if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt +1, stall_cnt unchanged.
- Freeze: dmem_req=1, dmem_ready=0 for 64 cycles with TIMEOUT_CYCLES=64 → all five stalls high throughout; mem_timeout_o=1 from cycle 65. Ready then rises → stalls drop. Assert rst → flag clears.
- FWD_EN=0: ID reads x3 while x3 is written by EX, then MEM, then WB → three consecutive stall cycles, selects always 00.
- Reset mid-freeze after 10 wait cycles → flushes=1 and stalls=0 during rst. After rst release with ready still low, 64 further freeze cycles are needed before the timeout flag sets.
